// File: rtl/rgb_pkg.sv
// Shared constants for the RGB PWM link. The encoder (rgb_controller) and the
// decoder (rgb_pwm_decoder) both take their defaults from here so that duty
// resolution and step prescale always agree on both ends of the link.
//
// Contents:
//   DUTY_W           duty resolution in bits (window = 2**DUTY_W sample ticks)
//   CLK_DIV_DEF      default CLK cycles per PWM step / sample tick
//   SYNC_STAGES_DEF  default synchroniser depth on the decoder inputs
//   duty_t           one colour channel duty value
//   WARMUP/MEASURE   decoder FSM state encodings
package rgb_pkg;

   localparam int unsigned DUTY_W          = 8;
   localparam int unsigned CLK_DIV_DEF     = 1;
   localparam int unsigned SYNC_STAGES_DEF = 2;

   typedef logic [DUTY_W-1:0] duty_t;

   // Decoder FSM states
   localparam logic [0:0] WARMUP  = 1'b0;
   localparam logic [0:0] MEASURE = 1'b1;

endpackage

// File: rtl/pwm_high_counter.sv
// One channel of the PWM decoder: synchronises an asynchronous PWM input and
// counts the sample ticks on which it is high across one measurement window.
//
// Ports:
//   CLK      system clock
//   RST      asynchronous active-low reset
//   pwm_in   asynchronous PWM input
//   tick     sample strobe from the shared prescaler
//   win_end  tick is the last one of the window; counter clears at this edge
//   duty     saturated high count including the current sample (valid when win_end)
module pwm_high_counter
   import rgb_pkg::*;
#(
   parameter int unsigned WIDTH       = DUTY_W,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             pwm_in,
   input  logic             tick,
   input  logic             win_end,
   output logic [WIDTH-1:0] duty
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [WIDTH:0]         cnt_q, cnt_d;
   logic                   sample;
   logic [WIDTH:0]         total;

   assign sample = sync_q[SYNC_STAGES-1];

   always_comb begin
      // Final sample of the window is folded in here so the result is ready
      // on the same edge that clears the counter.
      total = cnt_q + (WIDTH+1)'(sample);
      // A full window of highs gives 2**WIDTH, which saturates to all-ones.
      duty  = total[WIDTH] ? '1 : total[WIDTH-1:0];
      cnt_d = cnt_q;
      if (tick) begin
         cnt_d = win_end ? '0 : total;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync_q <= '0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/rgb_pwm_decoder.sv
// Receive side of the RGB PWM link: measures the duty of three PWM inputs over
// fixed windows of 2**WIDTH sample ticks and hands each result to a consumer
// over a valid/ready handshake.
//
// Ports:
//   CLK            system clock
//   RST            asynchronous active-low reset
//   pwm_r/g/b_in   asynchronous PWM inputs
//   ready_in       consumer accepts the result when valid_out && ready_in
//   r/g/b_out      measured duty per channel (held between loads)
//   valid_out      result available; held stable while high
//   changed_out    current result differs from the previously delivered one
//   overrun_out    sticky: a completed result was dropped (consumer too slow)
module rgb_pwm_decoder
   import rgb_pkg::*;
#(
   parameter int unsigned WIDTH       = DUTY_W,
   parameter int unsigned CLK_DIV     = CLK_DIV_DEF,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             pwm_r_in,
   input  logic             pwm_g_in,
   input  logic             pwm_b_in,
   input  logic             ready_in,
   output logic [WIDTH-1:0] r_out,
   output logic [WIDTH-1:0] g_out,
   output logic [WIDTH-1:0] b_out,
   output logic             valid_out,
   output logic             changed_out,
   output logic             overrun_out
);

   localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [PW-1:0]    presc_q, presc_d;
   logic [WIDTH-1:0] win_q, win_d;
   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] r_q, g_q, b_q;
   logic [WIDTH-1:0] r_d, g_d, b_d;
   logic             valid_q, valid_d;
   logic             changed_q, changed_d;
   logic             overrun_q, overrun_d;
   logic             have_q, have_d;   // at least one result delivered since reset

   logic             tick, win_end, cand, load;
   logic [WIDTH-1:0] r_new, g_new, b_new;

   assign tick    = (presc_q == PW'(CLK_DIV - 1));
   assign win_end = tick && (win_q == '1);

   pwm_high_counter #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_cnt_r (
      .CLK     (CLK),
      .RST     (RST),
      .pwm_in  (pwm_r_in),
      .tick    (tick),
      .win_end (win_end),
      .duty    (r_new)
   );

   pwm_high_counter #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_cnt_g (
      .CLK     (CLK),
      .RST     (RST),
      .pwm_in  (pwm_g_in),
      .tick    (tick),
      .win_end (win_end),
      .duty    (g_new)
   );

   pwm_high_counter #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_cnt_b (
      .CLK     (CLK),
      .RST     (RST),
      .pwm_in  (pwm_b_in),
      .tick    (tick),
      .win_end (win_end),
      .duty    (b_new)
   );

   always_comb begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      win_d   = tick ? win_q + WIDTH'(1) : win_q;

      // The first window after reset is discarded while the synchronisers fill.
      state_d = state_q;
      if (win_end) begin
         state_d = MEASURE;
      end

      cand = win_end && (state_q == MEASURE);
      // Load when the output slot is empty or is being emptied this cycle.
      load = cand && (!valid_q || ready_in);

      r_d       = r_q;
      g_d       = g_q;
      b_d       = b_q;
      changed_d = changed_q;
      have_d    = have_q;
      valid_d   = valid_q;
      if (load) begin
         r_d       = r_new;
         g_d       = g_new;
         b_d       = b_new;
         changed_d = !have_q || (r_new != r_q) || (g_new != g_q) || (b_new != b_q);
         have_d    = 1'b1;
         valid_d   = 1'b1;
      end else if (valid_q && ready_in) begin
         valid_d = 1'b0;
      end

      overrun_d = overrun_q | (cand && !load);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         presc_q   <= '0;
         win_q     <= '0;
         state_q   <= WARMUP;
         r_q       <= '0;
         g_q       <= '0;
         b_q       <= '0;
         valid_q   <= 1'b0;
         changed_q <= 1'b0;
         overrun_q <= 1'b0;
         have_q    <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         win_q     <= win_d;
         state_q   <= state_d;
         r_q       <= r_d;
         g_q       <= g_d;
         b_q       <= b_d;
         valid_q   <= valid_d;
         changed_q <= changed_d;
         overrun_q <= overrun_d;
         have_q    <= have_d;
      end
   end

   assign r_out       = r_q;
   assign g_out       = g_q;
   assign b_out       = b_q;
   assign valid_out   = valid_q;
   assign changed_out = changed_q;
   assign overrun_out = overrun_q;

endmodule
